// File: rtl/rom_port_arbiter.sv
// Shares one single-port registered-output ROM BRAM between the download writer and two CPU
// fetch ports. Define ROM_ARB_CACHE_EN to add a one-entry last-address cache per read port.
module rom_port_arbiter #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       CPU_AW   = 15,
  parameter int unsigned       SND_AW   = 14,
  parameter logic [ADDR_W-1:0] SND_BASE = 16'h8000
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              dl_wr,
  input  logic [24:0]       dl_addr,
  input  logic [DATA_W-1:0] dl_data,
  output logic              dl_wait,
  input  logic              cpu_req,
  input  logic [CPU_AW-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_data,
  output logic              cpu_ack,
  input  logic              snd_req,
  input  logic [SND_AW-1:0] snd_addr,
  output logic [DATA_W-1:0] snd_data,
  output logic              snd_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_d,
  input  logic [DATA_W-1:0] mem_q
);

  typedef enum logic [1:0] {StIdle, StRdIssue, StRdWait, StWrIssue} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   mem_d_q, mem_d_d;
  logic [DATA_W-1:0]   cpu_data_q, cpu_data_d, snd_data_q, snd_data_d;
  logic                cpu_ack_q, cpu_ack_d, snd_ack_q, snd_ack_d;
  logic                pend_q, pend_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0]   pend_data_q, pend_data_d;
  logic                rr_q, rr_d;    // 1: sound wins the next tie
  logic                gnt_q, gnt_d;  // 1: sound owns the read in flight

  logic              dl_accept, cpu_vld, snd_vld, any_req, gnt_snd, hit;
  logic [ADDR_W-1:0] cpu_mem_addr, snd_mem_addr;

  assign dl_accept    = dl_wr && ((dl_addr >> ADDR_W) == 25'd0);
  assign cpu_mem_addr = ADDR_W'(cpu_addr);
  assign snd_mem_addr = SND_BASE + ADDR_W'(snd_addr);

  // A requester still sees its ack this cycle, so its level req is not a new request yet.
  assign cpu_vld = cpu_req && !cpu_ack_q;
  assign snd_vld = snd_req && !snd_ack_q;
  assign any_req = cpu_vld || snd_vld;
  assign gnt_snd = (cpu_vld && snd_vld) ? rr_q : snd_vld;

`ifdef ROM_ARB_CACHE_EN
  logic              cpu_tag_vld_q, cpu_tag_vld_d, snd_tag_vld_q, snd_tag_vld_d;
  logic [CPU_AW-1:0] cpu_tag_q, cpu_tag_d;
  logic [SND_AW-1:0] snd_tag_q, snd_tag_d;

  assign hit = gnt_snd ? (snd_tag_vld_q && (snd_tag_q == snd_addr))
                       : (cpu_tag_vld_q && (cpu_tag_q == cpu_addr));
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_d_d     = mem_d_q;
    cpu_data_d  = cpu_data_q;
    snd_data_d  = snd_data_q;
    cpu_ack_d   = 1'b0;
    snd_ack_d   = 1'b0;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    rr_d        = rr_q;
    gnt_d       = gnt_q;
`ifdef ROM_ARB_CACHE_EN
    cpu_tag_vld_d = cpu_tag_vld_q;
    snd_tag_vld_d = snd_tag_vld_q;
    cpu_tag_d     = cpu_tag_q;
    snd_tag_d     = snd_tag_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (pend_q) begin
          mem_addr_d = pend_addr_q;
          mem_d_d    = pend_data_q;
          mem_we_d   = 1'b1;
          pend_d     = 1'b0;
          state_d    = StWrIssue;
        end else if (any_req) begin
          gnt_d = gnt_snd;
          rr_d  = !gnt_snd;
          if (hit) begin
            cpu_ack_d = !gnt_snd;
            snd_ack_d = gnt_snd;
          end else begin
            mem_addr_d = gnt_snd ? snd_mem_addr : cpu_mem_addr;
            state_d    = StRdIssue;
`ifdef ROM_ARB_CACHE_EN
            if (gnt_snd) begin
              snd_tag_d     = snd_addr;
              snd_tag_vld_d = 1'b0;
            end else begin
              cpu_tag_d     = cpu_addr;
              cpu_tag_vld_d = 1'b0;
            end
`endif
          end
        end
      end
      StRdIssue: state_d = StRdWait;
      StRdWait: begin
        if (gnt_q) begin
          snd_data_d = mem_q;
          snd_ack_d  = 1'b1;
`ifdef ROM_ARB_CACHE_EN
          snd_tag_vld_d = 1'b1;
`endif
        end else begin
          cpu_data_d = mem_q;
          cpu_ack_d  = 1'b1;
`ifdef ROM_ARB_CACHE_EN
          cpu_tag_vld_d = 1'b1;
`endif
        end
        state_d = StIdle;
      end
      StWrIssue: state_d = StIdle;
      default:   state_d = StIdle;
    endcase

    // A new capture overrides the pending clear above; an overwrite is an upstream error.
    if (dl_accept) begin
      pend_d      = 1'b1;
      pend_addr_d = dl_addr[ADDR_W-1:0];
      pend_data_d = dl_data;
    end
`ifdef ROM_ARB_CACHE_EN
    if (dl_accept || (state_q == StIdle && pend_q)) begin
      cpu_tag_vld_d = 1'b0;
      snd_tag_vld_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_d_q     <= '0;
      cpu_data_q  <= '0;
      snd_data_q  <= '0;
      cpu_ack_q   <= 1'b0;
      snd_ack_q   <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      rr_q        <= 1'b0;
      gnt_q       <= 1'b0;
`ifdef ROM_ARB_CACHE_EN
      cpu_tag_vld_q <= 1'b0;
      snd_tag_vld_q <= 1'b0;
      cpu_tag_q     <= '0;
      snd_tag_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_d_q     <= mem_d_d;
      cpu_data_q  <= cpu_data_d;
      snd_data_q  <= snd_data_d;
      cpu_ack_q   <= cpu_ack_d;
      snd_ack_q   <= snd_ack_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      rr_q        <= rr_d;
      gnt_q       <= gnt_d;
`ifdef ROM_ARB_CACHE_EN
      cpu_tag_vld_q <= cpu_tag_vld_d;
      snd_tag_vld_q <= snd_tag_vld_d;
      cpu_tag_q     <= cpu_tag_d;
      snd_tag_q     <= snd_tag_d;
`endif
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_we   = mem_we_q;
  assign mem_d    = mem_d_q;
  assign cpu_data = cpu_data_q;
  assign snd_data = snd_data_q;
  assign cpu_ack  = cpu_ack_q;
  assign snd_ack  = snd_ack_q;
  assign dl_wait  = pend_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter with a behavioural single-port registered-output BRAM.
// Build with ROM_ARB_CACHE_EN defined to also exercise the read cache.
module tb_rom_port_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        dl_wr   = 1'b0;
  logic [24:0] dl_addr = '0;
  logic [7:0]  dl_data = '0;
  logic        dl_wait;
  logic        cpu_req = 1'b0;
  logic [14:0] cpu_addr = '0;
  logic [7:0]  cpu_data;
  logic        cpu_ack;
  logic        snd_req = 1'b0;
  logic [13:0] snd_addr = '0;
  logic [7:0]  snd_data;
  logic        snd_ack;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_d;
  logic [7:0]  mem_q;

  int checks   = 0;
  int failures = 0;

  logic [7:0] rom [0:65535];

  always #5 clk_sys = ~clk_sys;

  // Read-first BRAM: q reflects the address presented at the previous edge.
  always @(posedge clk_sys) begin
    if (mem_we) rom[mem_addr] <= mem_d;
    mem_q <= rom[mem_addr];
  end

  rom_port_arbiter dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .dl_wr    (dl_wr),
    .dl_addr  (dl_addr),
    .dl_data  (dl_data),
    .dl_wait  (dl_wait),
    .cpu_req  (cpu_req),
    .cpu_addr (cpu_addr),
    .cpu_data (cpu_data),
    .cpu_ack  (cpu_ack),
    .snd_req  (snd_req),
    .snd_addr (snd_addr),
    .snd_data (snd_data),
    .snd_ack  (snd_ack),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_d    (mem_d),
    .mem_q    (mem_q)
  );

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset;
    cpu_req = 1'b0; snd_req = 1'b0; dl_wr = 1'b0;
    dl_addr = '0; dl_data = '0; cpu_addr = '0; snd_addr = '0;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick;
    checks++;
    if ({mem_addr, mem_we, mem_d} !== 25'd0) begin
      failures++;
      $display("FAIL reset_mem: got addr=%h we=%b d=%h required 0", mem_addr, mem_we, mem_d);
    end
    checks++;
    if ({cpu_data, snd_data} !== 16'd0) begin
      failures++;
      $display("FAIL reset_data: got cpu=%h snd=%h required 0", cpu_data, snd_data);
    end
    checks++;
    if ({cpu_ack, snd_ack, dl_wait} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags: got cpu_ack=%b snd_ack=%b dl_wait=%b required 0",
               cpu_ack, snd_ack, dl_wait);
    end
    reset = 1'b0;
  endtask

  task automatic test_download;
    logic [24:0] wa [2];
    logic [7:0]  wd [2];
    wa[0] = 25'h0000; wd[0] = 8'hA5;
    wa[1] = 25'h8001; wd[1] = 8'h3C;
    do_reset;
    for (int i = 0; i < 2; i++) begin
      dl_wr = 1'b1; dl_addr = wa[i]; dl_data = wd[i];
      tick;
      dl_wr = 1'b0;
      checks++;
      if (dl_wait !== 1'b1 || mem_we !== 1'b0) begin
        failures++;
        $display("FAIL dl_capture%0d: got wait=%b we=%b required wait=1 we=0", i, dl_wait, mem_we);
      end
      tick;
      checks++;
      if ({mem_we, mem_addr, mem_d, dl_wait} !== {1'b1, wa[i][15:0], wd[i], 1'b0}) begin
        failures++;
        $display("FAIL dl_issue%0d: got we=%b addr=%h d=%h wait=%b required 1 %h %h 0",
                 i, mem_we, mem_addr, mem_d, dl_wait, wa[i][15:0], wd[i]);
      end
      tick;
      checks++;
      if (mem_we !== 1'b0) begin
        failures++;
        $display("FAIL dl_we_pulse%0d: got we=%b required 0", i, mem_we);
      end
      tick;
    end
    cpu_req = 1'b1; cpu_addr = 15'h0000;
    for (int t = 1; t <= 3; t++) begin
      tick;
      checks++;
      if (cpu_ack !== (t == 3)) begin
        failures++;
        $display("FAIL cpu_latency t=%0d: got ack=%b required %b", t, cpu_ack, (t == 3));
      end
    end
    cpu_req = 1'b0;
    checks++;
    if (cpu_data !== 8'hA5) begin
      failures++;
      $display("FAIL cpu_read0: got %h required a5", cpu_data);
    end
    tick;
    checks++;
    if (cpu_ack !== 1'b0 || cpu_data !== 8'hA5) begin
      failures++;
      $display("FAIL cpu_hold: got ack=%b data=%h required 0 a5", cpu_ack, cpu_data);
    end
    snd_req = 1'b1; snd_addr = 14'h0001;
    tick;
    tick;
    tick;
    snd_req = 1'b0;
    checks++;
    if (snd_ack !== 1'b1 || snd_data !== 8'h3C || cpu_ack !== 1'b0) begin
      failures++;
      $display("FAIL snd_read1: got ack=%b data=%h cpu_ack=%b required 1 3c 0",
               snd_ack, snd_data, cpu_ack);
    end
  endtask

  task automatic test_bad_addr;
    tick;
    dl_wr = 1'b1; dl_addr = 25'h10000; dl_data = 8'hFF;
    tick;
    dl_wr = 1'b0;
    for (int t = 0; t < 3; t++) begin
      checks++;
      if (dl_wait !== 1'b0 || mem_we !== 1'b0) begin
        failures++;
        $display("FAIL bad_addr t=%0d: got wait=%b we=%b required 0 0", t, dl_wait, mem_we);
      end
      tick;
    end
  endtask

  task automatic test_arbitration;
    logic [9:0] exp_cpu, exp_snd;
`ifdef ROM_ARB_CACHE_EN
    exp_cpu = 10'b1010001000;
    exp_snd = 10'b0101000000;
`else
    exp_cpu = 10'b1000001000;
    exp_snd = 10'b0001000000;
`endif
    do_reset;
    cpu_req = 1'b1; cpu_addr = 15'h0000;
    snd_req = 1'b1; snd_addr = 14'h0001;
    for (int t = 1; t <= 9; t++) begin
      tick;
      checks++;
      if ({cpu_ack, snd_ack} !== {exp_cpu[t], exp_snd[t]}) begin
        failures++;
        $display("FAIL rr_acks t=%0d: got cpu=%b snd=%b required cpu=%b snd=%b",
                 t, cpu_ack, snd_ack, exp_cpu[t], exp_snd[t]);
      end
      if (exp_cpu[t]) begin
        checks++;
        if (cpu_data !== 8'hA5) begin
          failures++;
          $display("FAIL rr_cpu_data t=%0d: got %h required a5", t, cpu_data);
        end
      end
      if (exp_snd[t]) begin
        checks++;
        if (snd_data !== 8'h3C) begin
          failures++;
          $display("FAIL rr_snd_data t=%0d: got %h required 3c", t, snd_data);
        end
      end
    end
    cpu_req = 1'b0; snd_req = 1'b0;
    tick;
  endtask

  task automatic test_write_during_read;
    do_reset;
    cpu_req = 1'b1; cpu_addr = 15'h0000;
    tick;
    dl_wr = 1'b1; dl_addr = 25'h0002; dl_data = 8'h5A;
    tick;
    dl_wr = 1'b0;
    checks++;
    if (dl_wait !== 1'b1 || cpu_ack !== 1'b0 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL wdr_e1: got wait=%b ack=%b we=%b required 1 0 0", dl_wait, cpu_ack, mem_we);
    end
    tick;
    cpu_req = 1'b0;
    checks++;
    if ({cpu_ack, cpu_data, mem_we, dl_wait} !== {1'b1, 8'hA5, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL wdr_e2: got ack=%b data=%h we=%b wait=%b required 1 a5 0 1",
               cpu_ack, cpu_data, mem_we, dl_wait);
    end
    tick;
    checks++;
    if ({mem_we, mem_addr, mem_d, dl_wait} !== {1'b1, 16'h0002, 8'h5A, 1'b0}) begin
      failures++;
      $display("FAIL wdr_issue: got we=%b addr=%h d=%h wait=%b required 1 0002 5a 0",
               mem_we, mem_addr, mem_d, dl_wait);
    end
    tick;
    checks++;
    if (mem_we !== 1'b0 || cpu_ack !== 1'b0) begin
      failures++;
      $display("FAIL wdr_after: got we=%b ack=%b required 0 0", mem_we, cpu_ack);
    end
  endtask

  task automatic test_reset_in_rd_wait;
    do_reset;
    cpu_req = 1'b1; cpu_addr = 15'h0002;
    tick;
    tick;
    reset = 1'b1;
    #1;
    checks++;
    if ({cpu_ack, mem_addr} !== {1'b0, 16'h0000}) begin
      failures++;
      $display("FAIL async_reset: got ack=%b addr=%h required 0 0000", cpu_ack, mem_addr);
    end
    cpu_req = 1'b0;
    tick;
    tick;
    reset = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick;
      checks++;
      if (cpu_ack !== 1'b0 || snd_ack !== 1'b0) begin
        failures++;
        $display("FAIL no_stale_ack t=%0d: got cpu=%b snd=%b required 0 0", t, cpu_ack, snd_ack);
      end
    end
    cpu_req = 1'b1; cpu_addr = 15'h0002;
    tick;
    tick;
    tick;
    cpu_req = 1'b0;
    checks++;
    if (cpu_ack !== 1'b1 || cpu_data !== 8'h5A) begin
      failures++;
      $display("FAIL reread: got ack=%b data=%h required 1 5a", cpu_ack, cpu_data);
    end
    tick;
  endtask

`ifdef ROM_ARB_CACHE_EN
  task automatic test_cache;
    do_reset;
    cpu_req = 1'b1; cpu_addr = 15'h0000;
    tick; tick; tick;
    cpu_req = 1'b0;
    checks++;
    if (cpu_ack !== 1'b1 || cpu_data !== 8'hA5) begin
      failures++;
      $display("FAIL cache_miss: got ack=%b data=%h required 1 a5", cpu_ack, cpu_data);
    end
    tick;
    snd_req = 1'b1; snd_addr = 14'h0001;
    tick; tick; tick;
    snd_req = 1'b0;
    tick;
    cpu_req = 1'b1; cpu_addr = 15'h0000;
    tick;
    cpu_req = 1'b0;
    checks++;
    if ({cpu_ack, cpu_data, mem_addr} !== {1'b1, 8'hA5, 16'h8001}) begin
      failures++;
      $display("FAIL cache_hit: got ack=%b data=%h addr=%h required 1 a5 8001",
               cpu_ack, cpu_data, mem_addr);
    end
    tick;
    dl_wr = 1'b1; dl_addr = 25'h0000; dl_data = 8'h11;
    tick;
    dl_wr = 1'b0;
    tick; tick;
    cpu_req = 1'b1; cpu_addr = 15'h0000;
    for (int t = 1; t <= 3; t++) begin
      tick;
      checks++;
      if (cpu_ack !== (t == 3)) begin
        failures++;
        $display("FAIL cache_inval t=%0d: got ack=%b required %b", t, cpu_ack, (t == 3));
      end
    end
    cpu_req = 1'b0;
    checks++;
    if (cpu_data !== 8'h11) begin
      failures++;
      $display("FAIL cache_newdata: got %h required 11", cpu_data);
    end
    tick;
  endtask
`endif

  initial begin
    test_reset;
    test_download;
    test_bad_addr;
    test_arbitration;
    test_write_during_read;
    test_reset_in_rd_wait;
`ifdef ROM_ARB_CACHE_EN
    test_cache;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
